// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: reset-time init sweep, then r0/r1 arbitration.
// Optional macro REGFILE_ARB_ROUND_ROBIN_EN: round-robin on contention.
module regfile_write_arbiter #(
  parameter int                 XLEN     = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 NUM_REGS = 32,
  parameter logic [XLEN-1:0]    INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [XLEN-1:0]   r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [XLEN-1:0]   r1_data,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  output logic              init_busy
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic              gnt0;
  logic              gnt1;
  logic              in_init;

  assign in_init   = (state == S_INIT);
  assign init_busy = in_init;
  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;

  // State register; reset always re-enters the init sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_n;
  end

  // Leave INIT on the edge that issues the last init write.
  always_comb begin
    state_n = state;
    if (in_init && cnt == LAST) state_n = S_RUN;
  end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // ptr holds the last granted index; 1 lets r0 win first contention.
  logic ptr;

  // Grant opposite to the last winner on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!in_init) begin
      if (r0_valid && r1_valid) begin
        gnt0 = ptr;
        gnt1 = ~ptr;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  // Track the most recently granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr <= 1'b1;
    else if (gnt0 || gnt1) ptr <= gnt1;
  end
`else
  // Fixed priority: r0 always beats r1.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!in_init) begin
      gnt0 = r0_valid;
      gnt1 = r1_valid & ~r0_valid;
    end
  end
`endif

  // Init address counter, only advances during the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= FIRST;
    else if (in_init) cnt <= cnt + FIRST;
  end

  // Registered write port; x0 writes complete but keep we3 low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      unique case (1'b1)
        in_init: begin
          we3 <= 1'b1;
          a3  <= cnt;
          wd3 <= INIT_VAL;
        end
        gnt0: begin
          we3 <= |r0_addr;
          a3  <= r0_addr;
          wd3 <= r0_data;
        end
        gnt1: begin
          we3 <= |r1_addr;
          a3  <= r1_addr;
          wd3 <= r1_data;
        end
        default: we3 <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the register file's single write port (we3/a3/wd3). Shares it between two writeback requesters: r0 is the ALU/writeback path, r1 is the load/memory path. Uses a valid/ready handshake per requester. After every reset, it first runs an init sequencer that writes INIT_VAL into x1..x31, so the register file never holds X after reset.

Parameters:
XLEN, 32, data width of wd3 and requester data.
ADDR_W, 5, register address width.
NUM_REGS, 32, number of architectural registers; init covers 1..NUM_REGS-1.
INIT_VAL, 32'h0000_0000, value written to every register during init.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
r0_valid  input  1  requester 0 has a write pending.
r0_ready  output  1  requester 0 write accepted this cycle.
r0_addr  input  ADDR_W  requester 0 destination register.
r0_data  input  XLEN  requester 0 write data.
r1_valid  input  1  requester 1 has a write pending.
r1_ready  output  1  requester 1 write accepted this cycle.
r1_addr  input  ADDR_W  requester 1 destination register.
r1_data  input  XLEN  requester 1 write data.
we3  output  1  register file write enable (registered).
a3  output  ADDR_W  register file write address (registered).
wd3  output  XLEN  register file write data (registered).
init_busy  output  1  high while the init sequence runs.

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, init counter=1, we3=0, a3=0, wd3=0, init_busy=1.
  - r0_ready=r1_ready=0; round-robin pointer=1 (r0 wins the first contention).
- Reset mid-operation: all of the above apply immediately. In-flight accepted writes are lost and init restarts from x1.
- State INIT:
  - Each rising edge registers we3=1, a3=cnt, wd3=INIT_VAL, then increments cnt.
  - The write for cnt=NUM_REGS-1 is the last one. The same edge moves the block to RUN.
  - Result: exactly NUM_REGS-1 (31) consecutive write cycles.
  - Both readies stay 0 throughout INIT. init_busy is 1 in INIT and 0 in RUN.
- State RUN, arbitration (combinational, fixed priority when the macro is absent):
  - r0_ready = r0_valid.
  - r1_ready = r1_valid & ~r0_valid.
  - Readies are never high while the corresponding valid is low. At most one ready is high per cycle.
- Fire: valid&ready sampled on a rising edge. On that same edge the output registers load:
  - we3 = (addr != 0),
  - a3 = addr,
  - wd3 = data.
  - The register file commits on the following edge, so there is one cycle of latency from acceptance to the register file write.
- No fire in a cycle: we3<=0; a3 and wd3 hold their previous values.
- Writes to x0: the handshake completes (ready=1) but we3 stays 0.
- Requester obligations: a requester holds valid, addr and data stable until it sees ready. Dropping valid before ready is illegal, and the bench flags it.
- Throughput: one write per cycle sustained. The losing requester stalls for as long as the winner keeps valid high.
- No internal buffering; the block never reorders writes within a requester.
- RUN is left only by reset.

Optional Feature:
REGFILE_ARB_ROUND_ROBIN_EN
- Defined: when both valids are high in RUN, grant the requester opposite to the pointer. The pointer updates to the granted index on every fire, so contention alternates r0,r1,r0,...
  - A single valid requester is always granted regardless of the pointer.
- Undefined: strict fixed priority r0 > r1. The pointer is removed from the RTL.

Test Plan:
- Release rst_n, drive no requests -> we3=1 for exactly 31 cycles with a3 = 1..31 and wd3 = 0; init_busy drops the cycle after a3=31; readies stay 0 throughout.
- RUN, r0_valid=1, r0_addr=5, r0_data=32'hDEADBEEF for one cycle -> r0_ready=1 that cycle; next cycle we3=1, a3=5, wd3=32'hDEADBEEF; the cycle after, we3=0.
- RUN, r0 and r1 both valid (addr 3 / 4) for 4 cycles:
  - Without the macro: r1_ready=0 throughout and a3 stays 3.
  - With REGFILE_ARB_ROUND_ROBIN_EN: grants go r0,r1,r0,r1 and a3 goes 3,4,3,4.
- RUN, r1_valid=1, r1_addr=0, r1_data=32'h1234 -> r1_ready=1, but the next cycle we3=0.
- Assert rst_n=0 when a3=10 during INIT, release after 2 cycles -> we3=0 while in reset; the sequence restarts at a3=1 and still totals 31 writes.
- Back-to-back r0 writes to x7 then x8 on consecutive cycles -> we3 stays 1 for two consecutive cycles with a3=7 then 8, and no cycle is dropped.
